// File: rtl/hsv_hue_histogram.sv
// Per-frame 12-bin hue histogram (30 degrees per bin) over a valid/ready pixel stream.
// Bins are read out bin 0..11 over a valid/ready port at end of frame, then cleared.
module hsv_hue_histogram #(
   parameter logic [7:0] S_MIN = 8'd40,
   parameter logic [7:0] V_MIN = 8'd32,
   parameter int         CNT_W = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sof,
   input  logic             eof,
   input  logic [8:0]       h,
   input  logic [7:0]       s,
   input  logic [7:0]       v,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [3:0]       rd_bin,
   output logic [CNT_W-1:0] rd_count,
   output logic             rd_sat,
   output logic             rd_last,
   output logic             busy
);

   localparam int               N_BINS  = 12;
   localparam logic [3:0]       LAST_BIN = 4'd11;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_DUMP,
      ST_CLEAR
   } state_t;

   state_t state_q, state_d;
   logic   drain_q, drain_d;

   logic       s1_valid_q, s1_valid_d;
   logic       s1_qual_q, s1_qual_d;
   logic       s1_eof_q, s1_eof_d;
   logic [3:0] s1_bin_q, s1_bin_d;

   logic             s2_valid_q, s2_valid_d;
   logic             s2_qual_q, s2_qual_d;
   logic             s2_eof_q, s2_eof_d;
   logic [3:0]       s2_bin_q, s2_bin_d;
   logic [CNT_W-1:0] s2_cnt_q, s2_cnt_d;
   logic             s2_sat_q, s2_sat_d;

   logic [CNT_W-1:0]  bins_q [N_BINS];
   logic [CNT_W-1:0]  bins_d [N_BINS];
   logic [N_BINS-1:0] sat_q, sat_d;
   logic [3:0]        rd_bin_q, rd_bin_d;

   logic             xfer;
   logic             take;
   logic             qualify;
   logic [CNT_W-1:0] fwd_cnt;

   // Bin index by threshold comparison so no divider is inferred.
   function automatic logic [3:0] hue_bin(input logic [8:0] hue);
      logic [3:0] b;
      b = 4'd0;
      for (int k = 1; k < N_BINS; k++) begin
         if (hue >= 9'(30 * k)) b = 4'(k);
      end
      return b;
   endfunction

   assign in_ready = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
   assign busy     = (state_q == ST_DUMP) || (state_q == ST_CLEAR);
   assign rd_valid = (state_q == ST_DUMP);
   assign rd_bin   = rd_bin_q;
   assign rd_count = rd_valid ? bins_q[rd_bin_q] : '0;
   assign rd_sat   = rd_valid && sat_q[rd_bin_q];
   assign rd_last  = rd_valid && (rd_bin_q == LAST_BIN);

   assign xfer    = in_valid && in_ready;
   // Once eof is in flight, further non-sof pixels belong to no frame and are dropped.
   assign take    = xfer && (sof || ((state_q == ST_ACCUM) && !drain_q));
   assign qualify = (h < 9'd360) && (s >= S_MIN) && (v >= V_MIN);

   // Stage 2 writes its count at the same edge stage 1 reads, so forward it.
   assign fwd_cnt = (s2_valid_q && s2_qual_q && (s2_bin_q == s1_bin_q)) ? s2_cnt_q
                                                                         : bins_q[s1_bin_q];

   always_comb begin
      state_d  = state_q;
      drain_d  = drain_q;
      rd_bin_d = rd_bin_q;
      bins_d   = bins_q;
      sat_d    = sat_q;

      s1_valid_d = take;
      s1_qual_d  = qualify;
      s1_bin_d   = hue_bin(h);
      s1_eof_d   = eof;

      s2_valid_d = s1_valid_q;
      s2_qual_d  = s1_qual_q;
      s2_bin_d   = s1_bin_q;
      s2_eof_d   = s1_eof_q;
      s2_cnt_d   = (fwd_cnt == CNT_MAX) ? fwd_cnt : fwd_cnt + CNT_ONE;
      s2_sat_d   = (fwd_cnt == CNT_MAX);

      if (s2_valid_q && s2_qual_q) begin
         bins_d[s2_bin_q] = s2_cnt_q;
         sat_d[s2_bin_q]  = sat_q[s2_bin_q] | s2_sat_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (take) begin
               state_d = ST_ACCUM;
               drain_d = eof;
            end
         end
         ST_ACCUM: begin
            if (xfer && sof) begin
               for (int i = 0; i < N_BINS; i++) bins_d[i] = '0;
               sat_d      = '0;
               s2_valid_d = 1'b0;
               drain_d    = eof;
            end else if (s2_valid_q && s2_eof_q) begin
               state_d  = ST_DUMP;
               drain_d  = 1'b0;
               rd_bin_d = 4'd0;
            end else if (take && eof) begin
               drain_d = 1'b1;
            end
         end
         ST_DUMP: begin
            if (rd_ready) begin
               if (rd_bin_q == LAST_BIN) state_d = ST_CLEAR;
               else                      rd_bin_d = rd_bin_q + 4'd1;
            end
         end
         ST_CLEAR: begin
            for (int i = 0; i < N_BINS; i++) bins_d[i] = '0;
            sat_d    = '0;
            rd_bin_d = 4'd0;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         drain_q    <= 1'b0;
         rd_bin_q   <= 4'd0;
         // NOTE: the bin array is a small flop bank, not a RAM, so it is reset so that
         // a reset mid-frame cannot leak stale counts into the next frame.
         for (int i = 0; i < N_BINS; i++) bins_q[i] <= '0;
         sat_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_qual_q  <= 1'b0;
         s1_eof_q   <= 1'b0;
         s1_bin_q   <= 4'd0;
         s2_valid_q <= 1'b0;
         s2_qual_q  <= 1'b0;
         s2_eof_q   <= 1'b0;
         s2_bin_q   <= 4'd0;
         s2_cnt_q   <= '0;
         s2_sat_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         drain_q    <= drain_d;
         rd_bin_q   <= rd_bin_d;
         bins_q     <= bins_d;
         sat_q      <= sat_d;
         s1_valid_q <= s1_valid_d;
         s1_qual_q  <= s1_qual_d;
         s1_eof_q   <= s1_eof_d;
         s1_bin_q   <= s1_bin_d;
         s2_valid_q <= s2_valid_d;
         s2_qual_q  <= s2_qual_d;
         s2_eof_q   <= s2_eof_d;
         s2_bin_q   <= s2_bin_d;
         s2_cnt_q   <= s2_cnt_d;
         s2_sat_q   <= s2_sat_d;
      end
   end

endmodule
